// File: rtl/norm_cdf_pair.sv
// norm_cdf_pair: iterative standard-normal CDF for the pair (d1, d2).
// N(x) is a piecewise-linear interpolation over T[i] = N(0.25*i) in Q16.16.
// One datapath is shared and walks ABS -> LUT -> MUL -> FIX, first for d1 and then for d2.
module norm_cdf_pair #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] Nd1,
   output logic [WIDTH-1:0] Nd2,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {IDLE, ABS, LUT, MUL, FIX, DONE} state_t;

   state_t      state, state_nxt;
   logic        sel;
   logic [31:0] d1_r, d2_r;
   logic        sign, sat;
   logic [3:0]  idx;
   logic [13:0] frac;
   logic [16:0] lo, hi;
   logic [31:0] p;
   logic [31:0] r1, r2;

   // N(0.25*i) * 65536, rounded.
   function automatic logic [16:0] cdf_lut(input logic [4:0] i);
      case (i)
         5'd0:    cdf_lut = 17'd32768;
         5'd1:    cdf_lut = 17'd39237;
         5'd2:    cdf_lut = 17'd45316;
         5'd3:    cdf_lut = 17'd50684;
         5'd4:    cdf_lut = 17'd55138;
         5'd5:    cdf_lut = 17'd58612;
         5'd6:    cdf_lut = 17'd61158;
         5'd7:    cdf_lut = 17'd62911;
         5'd8:    cdf_lut = 17'd64045;
         5'd9:    cdf_lut = 17'd64735;
         5'd10:   cdf_lut = 17'd65129;
         5'd11:   cdf_lut = 17'd65341;
         5'd12:   cdf_lut = 17'd65448;
         5'd13:   cdf_lut = 17'd65498;
         5'd14:   cdf_lut = 17'd65521;
         5'd15:   cdf_lut = 17'd65530;
         default: cdf_lut = 17'd65534;
      endcase
   endfunction

   // Combinational datapath terms for the current pass.
   logic [31:0] x, abs_x;
   logic [30:0] prod;
   logic [31:0] n_val, res_val;

   // Operand select, magnitude, interpolation product and final fix-up.
   always_comb begin
      x       = sel ? d2_r : d1_r;
      abs_x   = x[31] ? (32'd0 - x) : x;
      prod    = {14'd0, (hi - lo)} * {17'd0, frac};
      n_val   = sat ? 32'd65536 : ({15'd0, lo} + p);
      res_val = sign ? (32'd65536 - n_val) : n_val;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ABS;
         ABS:     state_nxt = LUT;
         LUT:     state_nxt = MUL;
         MUL:     state_nxt = FIX;
         FIX:     state_nxt = sel ? DONE : ABS;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, pass registers and outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         sel   <= 1'b0;
         d1_r  <= '0;
         d2_r  <= '0;
         sign  <= 1'b0;
         sat   <= 1'b0;
         idx   <= '0;
         frac  <= '0;
         lo    <= '0;
         hi    <= '0;
         p     <= '0;
         r1    <= '0;
         r2    <= '0;
         Nd1   <= '0;
         Nd2   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state != IDLE);
         done  <= (state == DONE);
         case (state)
            IDLE: if (start) begin
               d1_r <= d1;
               d2_r <= d2;
               sel  <= 1'b0;
            end
            ABS: begin
               sign <= x[31];
               // |x| >= 4.0 covers both signs, and 0x80000000 negates to itself.
               sat  <= (abs_x >= 32'd262144);
               idx  <= abs_x[17:14];
               frac <= abs_x[13:0];
            end
            LUT: begin
               lo <= cdf_lut({1'b0, idx});
               hi <= cdf_lut({1'b0, idx} + 5'd1);
            end
            MUL: p <= 32'(prod >> 14);
            FIX: begin
               if (sel) r2 <= res_val;
               else     r1 <= res_val;
               sel <= 1'b1;
            end
            DONE: begin
               Nd1 <= r1;
               Nd2 <= r2;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_norm_cdf_pair.sv
// Bench for norm_cdf_pair: arithmetic reference model plus directed vectors.
module tb_norm_cdf_pair;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] d1, d2;
   logic [31:0] Nd1, Nd2;
   logic        busy, done;

   norm_cdf_pair #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .d1(d1), .d2(d2),
      .Nd1(Nd1), .Nd2(Nd2), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   int T[17] = '{32768, 39237, 45316, 50684, 55138, 58612, 61158, 62911, 64045,
                 64735, 65129, 65341, 65448, 65498, 65521, 65530, 65534};

   // N(x) for Q16.16 x: interpolate |x| between quarter-unit table points, mirror for negatives.
   function automatic int ncdf(input logic [31:0] xv);
      int     sx;
      longint a;
      int     n, i, f;
      sx = int'(xv);
      a  = sx;
      if (a < 0) a = -a;
      if (a >= 262144) n = 65536;
      else begin
         i = int'(a / 16384);
         f = int'(a % 16384);
         n = T[i] + ((T[i+1] - T[i]) * f) / 16384;
      end
      return (sx < 0) ? 65536 - n : n;
   endfunction

   // Reference timing: results appear 9 edges after acceptance, busy covers edges 1..9.
   int  m_nd1 = 0, m_nd2 = 0, m_c1 = 0, m_c2 = 0, m_k = 0;
   bit  m_busy = 0, m_done = 0, m_act = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_nd1 <= 0; m_nd2 <= 0; m_busy <= 0; m_done <= 0; m_act <= 0; m_k <= 0;
      end else if (!m_act) begin
         m_busy <= 0;
         m_done <= 0;
         if (start) begin
            m_act <= 1;
            m_k   <= 0;
            m_c1  <= ncdf(d1);
            m_c2  <= ncdf(d2);
         end
      end else begin
         m_busy <= 1;
         m_done <= (m_k == 8);
         m_k    <= m_k + 1;
         if (m_k == 8) begin
            m_nd1 <= m_c1;
            m_nd2 <= m_c2;
            m_act <= 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model once reset has settled.
   bit cmp_en = 0;
   int done_cnt = 0;
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_Nd1", longint'(Nd1), longint'(m_nd1));
         chk("cyc_Nd2", longint'(Nd2), longint'(m_nd2));
         chk("cyc_busy", longint'(busy), longint'(m_busy));
         chk("cyc_done", longint'(done), longint'(m_done));
         if (done) done_cnt++;
      end
   end

   task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                           input int e1, input int e2, input bit poke, input string nm);
      int lat, bcnt, d0;
      d0 = done_cnt;
      d1 = a; d2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; bcnt = 0;
      while (lat < 20) begin
         @(posedge clk); lat++; #1;
         if (busy) bcnt++;
         if (poke) begin
            // Extra requests sampled at E0+3 and E0+6 must be ignored.
            start = (lat == 2 || lat == 5);
            d1 = 32'd131072;
            d2 = 32'd196608;
         end
         if (done) break;
      end
      start = 1'b0;
      chk({nm, "_latency"}, lat, 9);
      chk({nm, "_busy_cycles"}, bcnt, 9);
      chk({nm, "_Nd1"}, longint'(Nd1), e1);
      chk({nm, "_Nd2"}, longint'(Nd2), e2);
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_done_pulses"}, done_cnt - d0, 1);
   endtask

   initial begin
      int d0;
      reset = 1'b0; start = 1'b0; d1 = '0; d2 = '0;

      // Model pinned to hand-computed values.
      chk("model_1p0", ncdf(32'd65536), 55138);
      chk("model_m1p0", ncdf(-32'sd65536), 10398);
      chk("model_0p125", ncdf(32'd8192), 36002);
      chk("model_m0p125", ncdf(-32'sd8192), 29534);
      chk("model_zero", ncdf(32'd0), 32768);
      chk("model_min", ncdf(32'h80000000), 0);

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      cmp_en = 1'b1;
      chk("rst_Nd1", longint'(Nd1), 0);
      chk("rst_Nd2", longint'(Nd2), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("idle_no_done", done_cnt, 0);

      run_pair(32'd65536, -32'sd65536, 55138, 10398, 1'b0, "basic");
      run_pair(32'd8192, -32'sd8192, 36002, 29534, 1'b0, "interp");
      run_pair(32'd0, 32'd0, 32768, 32768, 1'b0, "zero");
      run_pair(32'd327680, -32'sd327680, 65536, 0, 1'b0, "sat5");
      run_pair(32'd262144, 32'h80000000, 65536, 0, 1'b0, "sat4");
      run_pair(-32'sd65536, 32'd65536, 10398, 55138, 1'b1, "handshake");

      // Reset during the d2 pass discards the request.
      d1 = 32'd8192; d2 = 32'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      chk("midrst_Nd1", longint'(Nd1), 0);
      chk("midrst_Nd2", longint'(Nd2), 0);
      chk("midrst_busy", longint'(busy), 0);
      d0 = done_cnt;
      repeat (12) @(posedge clk);
      #1;
      chk("midrst_no_done", done_cnt - d0, 0);
      run_pair(32'd65536, -32'sd65536, 55138, 10398, 1'b0, "after_rst");

      // start held high re-triggers every 10 cycles.
      d0 = done_cnt;
      d1 = 32'd8192; d2 = 32'd0; start = 1'b1;
      repeat (22) @(posedge clk);
      #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("held_start_dones", done_cnt - d0, 3);
      chk("held_start_Nd1", longint'(Nd1), 36002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/norm_cdf_pair.md
# norm_cdf_pair

Iterative fixed-point evaluator of the standard normal CDF for the pair (d1, d2), producing the Nd1/Nd2 operands consumed by the option-price stage. It sits directly upstream of that stage, between the d1/d2 calculator and the price computation. All data is signed Q16.16. N(x) is computed by piecewise-linear interpolation over a 17-entry table. One shared datapath is used, first for d1 and then for d2.

## Interface
- WIDTH, 32, data width (Q16.16); fixed at 32, other values unsupported
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- start  input  1  request pulse; accepted only in IDLE
- d1  input  WIDTH  signed Q16.16, sampled on the accepting edge
- d2  input  WIDTH  signed Q16.16, sampled on the accepting edge
- Nd1  output  WIDTH  N(d1), Q16.16, range [0, 65536]; reset 0
- Nd2  output  WIDTH  N(d2), Q16.16, range [0, 65536]; reset 0
- busy  output  1  high from the cycle after acceptance through the DONE cycle; reset 0
- done  output  1  one-cycle pulse when Nd1/Nd2 update; reset 0

## Operation
- Table T[0..16] holds N(0.25·i) × 65536, rounded:
  - 32768, 39237, 45316, 50684, 55138, 58612, 61158, 62911, 64045, 64735, 65129, 65341, 65448, 65498, 65521, 65530, 65534.
- States: IDLE, ABS, LUT, MUL, FIX, DONE. A 1-bit `sel` register chooses the d1 or d2 pass.
- IDLE:
  - start=1 latches d1 and d2 into internal registers, clears sel, and moves to ABS.
  - start=0 stays in IDLE.
- ABS:
  - sign ← x[31].
  - a ← (x<0) ? −x : x.
  - sat ← 1 if x ≥ 262144 (4.0) or x ≤ −262144; this covers 0x80000000 without overflow.
  - idx ← a[17:14]; frac ← a[13:0].
- LUT: lo ← T[idx]; hi ← T[idx+1].
- MUL: p ← ((hi − lo) × frac) >>> 14. The product is < 2^27, held in a 32-bit register. Truncation is toward zero, since the product is non-negative.
- FIX:
  - n ← sat ? 65536 : lo + p.
  - result ← sign ? 65536 − n : n.
  - Result is stored to r1 when sel=0, or to r2 when sel=1.
  - If sel=0: set sel=1 and go to ABS (d2 pass). Otherwise go to DONE.
- DONE: Nd1 ← r1, Nd2 ← r2, done=1 for this cycle; return to IDLE.
- Boundary values:
  - x=0 gives 32768 exactly.
  - |x| ≥ 4.0 gives exactly 65536 (x positive) or 0 (x negative).
- Symmetry N(−x) = 65536 − N(x) holds bit-exactly.
- start while not in IDLE is ignored; no queuing.
- Nd1/Nd2 hold their values between done pulses. They never show partial results.

## Timing
- Accepting edge E0 (IDLE, start=1) is followed by the states below; the DONE state occupies the cycle after edge E0+9.

| Edges | State |
|---|---|
| E0+1..E0+4 | ABS, LUT, MUL, FIX for d1 |
| E0+5..E0+8 | ABS, LUT, MUL, FIX for d2 |
| E0+9 | DONE |

- At edge E0+9 the outputs Nd1/Nd2 update and done rises. done falls at E0+10.
- busy is high from E0+1 through the DONE cycle, and falls at E0+10.
- Throughput: one request per 10 cycles. start held high continuously re-triggers on the IDLE cycle after each DONE.
- reset=0 at any edge, including mid-pass:
  - state ← IDLE, sel ← 0.
  - Nd1, Nd2, r1, r2 ← 0; busy ← 0; done ← 0.
  - The in-flight request is discarded.
- reset has priority over start on the same edge.

## Test plan
- Reset sequence: hold reset=0 for 2 cycles, then release → Nd1=Nd2=0, busy=0, done=0. Idle with start=0 → no done pulse.
- Basic pair, d1=65536 (1.0), d2=−65536 (−1.0): pulse start → done exactly 9 edges after acceptance, Nd1=55138, Nd2=10398, busy high for 9 cycles.
- Interpolation and symmetry:
  - d1=8192 (0.125) → Nd1=36002; d2=−8192 → Nd2=29534.
  - d1=0, d2=0 → both 32768.
- Saturation:
  - d1=327680 (5.0) → 65536; d2=−327680 → 0.
  - d1=262144 (exactly 4.0) → 65536; d2=0x80000000 → 0.
- Handshake: pulse start again at E0+3 and E0+6 with different d1/d2 → ignored; results match the first request only; exactly one done pulse.
- Reset mid-operation: assert reset=0 at E0+5 → outputs 0, state IDLE, no done. A fresh start with d1=65536, d2=−65536 after release → 55138 / 10398 with normal latency.
